// File: rtl/ahb_defs.sv
// Shared AHB-Lite encodings and arbiter constants for the 5-master bus slice.
package ahb_defs;

    localparam int NUM_MASTERS = 5;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    // Beats still owed after the NONSEQ beat of a fixed-length burst.
    localparam logic [3:0] BEATS_REM_4  = 4'd3;
    localparam logic [3:0] BEATS_REM_8  = 4'd7;
    localparam logic [3:0] BEATS_REM_16 = 4'd15;

    typedef enum logic {
        ST_PARK    = 1'b0,
        ST_GRANTED = 1'b1
    } arb_state_t;

    function automatic logic [3:0] burst_remaining(input logic [2:0] hburst);
        logic [3:0] rem;
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  rem = BEATS_REM_4;
            HBURST_WRAP8,  HBURST_INCR8:  rem = BEATS_REM_8;
            HBURST_WRAP16, HBURST_INCR16: rem = BEATS_REM_16;
            default:                      rem = 4'd0;
        endcase
        return rem;
    endfunction

    function automatic logic [2:0] onehot_to_idx(input logic [NUM_MASTERS-1:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [2:0] wrap5(input int v);
        return 3'(v % NUM_MASTERS);
    endfunction

endpackage

// File: rtl/rr_pick5.sv
// Rotating-priority picker: first requester after 'last', with 'last' itself searched last.
module rr_pick5
    import ahb_defs::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [2:0]             last,
    output logic [NUM_MASTERS-1:0] grant,
    output logic                   valid
);

    logic [NUM_MASTERS-1:0] rot_req;
    logic [NUM_MASTERS-1:0] rot_gnt;

    // Rotate so position 0 is master last+1; a plain lowest-bit pick then gives round-robin order.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_rot
            assign rot_req[gi] = req[wrap5(int'(last) + 1 + gi)];
            assign grant[gi]   = rot_gnt[wrap5(gi + 2 * NUM_MASTERS - 1 - int'(last))];
        end
    endgenerate

    assign rot_gnt = rot_req & ~(rot_req - NUM_MASTERS'(1));
    assign valid   = |req;

endmodule

// File: rtl/ahb_arbiter5.sv
// Round-robin AHB-Lite arbiter for 5 masters with burst/lock protection and tenure limit.
module ahb_arbiter5
    import ahb_defs::*;
#(
    parameter int DEF_MASTER = 0,
    parameter int MAX_HOLD   = 16,
    parameter int HCW        = 5
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic                   hready,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hmastlock,
    output logic [NUM_MASTERS-1:0] addr_sel,
    output logic [NUM_MASTERS-1:0] data_sel,
    output logic [2:0]             hmaster,
    output logic [2:0]             hmaster_data
);

    localparam logic [NUM_MASTERS-1:0] DEF_SEL  = NUM_MASTERS'(1) << DEF_MASTER;
    localparam logic [2:0]             DEF_IDX  = 3'(DEF_MASTER);
    localparam logic [HCW-1:0]         HOLD_MAX = HCW'(MAX_HOLD);

    arb_state_t             state_reg, state_next;
    logic [NUM_MASTERS-1:0] addr_sel_reg, addr_sel_next;
    logic [NUM_MASTERS-1:0] data_sel_reg;
    logic [2:0]             hmaster_reg, hmaster_data_reg;
    logic [3:0]             beat_cnt_reg, beat_cnt_next;
    logic [HCW-1:0]         hold_cnt_reg, hold_cnt_next, hold_inc;

    logic [NUM_MASTERS-1:0] pick_gnt;
    logic                   pick_valid;
    logic                   owner_req, others_req, hold_ok, switch_ok;

    rr_pick5 u_pick (
        .req   (hbusreq),
        .last  (hmaster_reg),
        .grant (pick_gnt),
        .valid (pick_valid)
    );

    always_comb begin
        beat_cnt_next = beat_cnt_reg;
        case (htrans)
            HTRANS_NONSEQ: beat_cnt_next = burst_remaining(hburst);
            HTRANS_SEQ:    beat_cnt_next = (beat_cnt_reg != 4'd0) ? beat_cnt_reg - 4'd1 : beat_cnt_reg;
            HTRANS_IDLE:   beat_cnt_next = 4'd0;
            default:       beat_cnt_next = beat_cnt_reg;
        endcase
    end

    // Tenure limit is judged on the count including the beat accepted at this edge.
    assign hold_inc = ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ)) && !(&hold_cnt_reg)
                      ? hold_cnt_reg + HCW'(1) : hold_cnt_reg;

    assign owner_req  = |(hbusreq & addr_sel_reg);
    assign others_req = |(hbusreq & ~addr_sel_reg);
    assign hold_ok    = (MAX_HOLD == 0) || (hold_inc < HOLD_MAX) || !others_req;
    assign switch_ok  = (beat_cnt_next == 4'd0) && !hmastlock;

    always_comb begin
        addr_sel_next = addr_sel_reg;
        state_next    = state_reg;
        if (switch_ok) begin
            if (owner_req && hold_ok) begin
                state_next = ST_GRANTED;
            end else if (pick_valid) begin
                addr_sel_next = pick_gnt;
                state_next    = ST_GRANTED;
            end else begin
                addr_sel_next = DEF_SEL;
                state_next    = ST_PARK;
            end
        end
    end

    assign hold_cnt_next = (addr_sel_next != addr_sel_reg) ? '0 : hold_inc;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_reg        <= ST_PARK;
            addr_sel_reg     <= DEF_SEL;
            data_sel_reg     <= DEF_SEL;
            hmaster_reg      <= DEF_IDX;
            hmaster_data_reg <= DEF_IDX;
            beat_cnt_reg     <= 4'd0;
            hold_cnt_reg     <= '0;
        end else if (hready) begin
            state_reg        <= state_next;
            addr_sel_reg     <= addr_sel_next;
            data_sel_reg     <= addr_sel_reg;
            hmaster_reg      <= onehot_to_idx(addr_sel_next);
            hmaster_data_reg <= hmaster_reg;
            beat_cnt_reg     <= beat_cnt_next;
            hold_cnt_reg     <= hold_cnt_next;
        end
    end

    assign addr_sel     = addr_sel_reg;
    assign data_sel     = data_sel_reg;
    assign hmaster      = hmaster_reg;
    assign hmaster_data = hmaster_data_reg;

endmodule

// File: tb/tb_ahb_arbiter5.sv
// Directed and random checks of ahb_arbiter5 against a rule-level ownership model.
module tb_ahb_arbiter5;

    localparam int DEF_MASTER = 0;
    localparam int MAX_HOLD   = 4;
    localparam int HCW        = 5;
    localparam int HOLD_SAT   = (1 << HCW) - 1;

    logic       hclk = 1'b0;
    logic       hreset;
    logic [4:0] hbusreq;
    logic       hready;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hmastlock;
    logic [4:0] addr_sel, data_sel;
    logic [2:0] hmaster, hmaster_data;

    int total = 0;
    int bad   = 0;

    int m_owner = DEF_MASTER;
    int m_data  = DEF_MASTER;
    int m_beats = 0;
    int m_hold  = 0;

    ahb_arbiter5 #(.DEF_MASTER(DEF_MASTER), .MAX_HOLD(MAX_HOLD), .HCW(HCW)) dut (
        .hclk         (hclk),
        .hreset       (hreset),
        .hbusreq      (hbusreq),
        .hready       (hready),
        .htrans       (htrans),
        .hburst       (hburst),
        .hmastlock    (hmastlock),
        .addr_sel     (addr_sel),
        .data_sel     (data_sel),
        .hmaster      (hmaster),
        .hmaster_data (hmaster_data)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Ownership rules applied at one clock edge with the currently driven inputs.
    task automatic model_edge();
        int  nb, nh, no;
        bit  others, found;
        if (hreset) begin
            m_owner = DEF_MASTER; m_data = DEF_MASTER; m_beats = 0; m_hold = 0;
        end else if (hready) begin
            case (htrans)
                2'd2:    nb = (hburst < 2) ? 0 : (4 << (hburst / 2 - 1)) - 1;
                2'd3:    nb = (m_beats > 0) ? m_beats - 1 : 0;
                2'd0:    nb = 0;
                default: nb = m_beats;
            endcase
            nh = (htrans >= 2'd2) ? ((m_hold < HOLD_SAT) ? m_hold + 1 : HOLD_SAT) : m_hold;
            no = m_owner;
            if (nb == 0 && !hmastlock) begin
                others = 0;
                for (int j = 0; j < 5; j++) if (j != m_owner && hbusreq[j]) others = 1;
                if (hbusreq[m_owner] && (nh < MAX_HOLD || !others)) begin
                    no = m_owner;
                end else if (hbusreq != 5'd0) begin
                    found = 0;
                    for (int k = 1; k <= 5; k++) begin
                        if (!found && hbusreq[(m_owner + k) % 5]) begin
                            no = (m_owner + k) % 5;
                            found = 1;
                        end
                    end
                end else begin
                    no = DEF_MASTER;
                end
            end
            m_data  = m_owner;
            m_hold  = (no != m_owner) ? 0 : nh;
            m_owner = no;
            m_beats = nb;
        end
    endtask

    task automatic step(input string tag, input logic [4:0] req, input logic [1:0] tr,
                        input logic [2:0] bu, input logic lk, input logic rdy, input logic rst);
        hbusreq = req; htrans = tr; hburst = bu; hmastlock = lk; hready = rdy; hreset = rst;
        @(posedge hclk);
        model_edge();
        #1;
        chk({tag, ".addr_sel"},     8'(addr_sel),          8'(5'd1 << m_owner));
        chk({tag, ".data_sel"},     8'(data_sel),          8'(5'd1 << m_data));
        chk({tag, ".hmaster"},      8'(hmaster),           8'(m_owner));
        chk({tag, ".hmaster_data"}, 8'(hmaster_data),      8'(m_data));
        chk({tag, ".beat_cnt"},     8'(dut.beat_cnt_reg),  8'(m_beats));
        $display("step %-10s req=%b tr=%0d bu=%0d lk=%0d rdy=%0d rst=%0d -> addr_sel=%b data_sel=%b",
                 tag, req, tr, bu, lk, rdy, rst, addr_sel, data_sel);
    endtask

    initial begin
        // reset then idle
        step("reset0", 5'b00000, 2'd0, 3'd0, 1'b0, 1'b1, 1'b1);
        step("reset1", 5'b00000, 2'd0, 3'd0, 1'b0, 1'b1, 1'b1);
        step("idle",   5'b00000, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        chk("park_sel", 8'(addr_sel), 8'h01);

        // simple grant, data phase one beat later
        step("grant",  5'b00100, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        chk("grant_sel", 8'(addr_sel), 8'h04);
        step("grant_d", 5'b00100, 2'd2, 3'd0, 1'b0, 1'b1, 1'b0);
        chk("grant_data", 8'(data_sel), 8'h04);

        // round-robin on successive releases
        step("rr3", 5'b11011, 2'd2, 3'd0, 1'b0, 1'b1, 1'b0);
        chk("rr3_sel", 8'(addr_sel), 8'h08);
        step("rr4", 5'b10011, 2'd2, 3'd0, 1'b0, 1'b1, 1'b0);
        step("rr0", 5'b00011, 2'd2, 3'd0, 1'b0, 1'b1, 1'b0);
        step("rr1", 5'b00010, 2'd2, 3'd0, 1'b0, 1'b1, 1'b0);
        chk("rr1_sel", 8'(addr_sel), 8'h02);

        // INCR4 from master 1 is not interrupted by master 3
        step("b_ns",  5'b00010, 2'd2, 3'd3, 1'b0, 1'b1, 1'b0);
        step("b_s1",  5'b01000, 2'd3, 3'd3, 1'b0, 1'b1, 1'b0);
        step("b_s2",  5'b01000, 2'd3, 3'd3, 1'b0, 1'b1, 1'b0);
        chk("burst_hold", 8'(addr_sel), 8'h02);
        step("b_s3",  5'b01000, 2'd3, 3'd3, 1'b0, 1'b1, 1'b0);
        chk("burst_done", 8'(addr_sel), 8'h08);

        // wait states freeze everything
        for (int i = 0; i < 3; i++) step("wait", 5'b00101, 2'd2, 3'd3, 1'b0, 1'b0, 1'b0);
        chk("wait_sel", 8'(addr_sel), 8'h08);

        // locked sequence outlives the hold limit
        step("lk_ns", 5'b01101, 2'd2, 3'd1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step("lk_s", 5'b01101, 2'd3, 3'd1, 1'b1, 1'b1, 1'b0);
        chk("lock_keep", 8'(addr_sel), 8'h08);
        step("unlock", 5'b01101, 2'd3, 3'd1, 1'b0, 1'b1, 1'b0);
        chk("unlock_rot", 8'(addr_sel), 8'h01);

        // hold limit forces rotation 0 -> 4 after four beats
        step("h_ns", 5'b10001, 2'd2, 3'd1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("h_s", 5'b10001, 2'd3, 3'd1, 1'b0, 1'b1, 1'b0);
        chk("hold_rot", 8'(addr_sel), 8'h10);

        // reset in the middle of a WRAP8
        step("w8_ns", 5'b10000, 2'd2, 3'd4, 1'b0, 1'b1, 1'b0);
        step("w8_rst", 5'b10000, 2'd3, 3'd4, 1'b0, 1'b1, 1'b1);
        chk("rst_sel", 8'(addr_sel), 8'h01);
        chk("rst_beats", 8'(dut.beat_cnt_reg), 8'h00);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step("rand", 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 99) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter5.md
Name: ahb_arbiter5

Overview:
- Round-robin bus arbiter for up to 5 AHB-Lite masters sharing one slave-side path.
- Generates the one-hot address-phase select and the one-hot data-phase select that drive the team's 5:1 parallel AND-OR muxes (address/control mux and write-data mux).
- Burst-aware and lock-aware: never hands over mid fixed-length burst or during a locked sequence.
- Bounds bus tenure with a hold counter.

Parameters:
DEF_MASTER, 0, index (0-4) of the park master granted when no requests are pending.
MAX_HOLD, 16, max accepted address beats per tenure before forced rotation; 0 disables the limit.
HCW, 5, hold counter width; must satisfy 2^HCW > MAX_HOLD.

Ports:
hclk  input  1  bus clock, all state on rising edge.
hreset  input  1  synchronous reset, active-high.
hbusreq  input  5  per-master bus request, bit i = master i.
hready  input  1  bus-wide HREADY; all state advances only when 1.
htrans  input  2  muxed HTRANS of current address-phase owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
hburst  input  3  muxed HBURST of owner (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7).
hmastlock  input  1  muxed HMASTLOCK of owner.
addr_sel  output  5  one-hot address-phase mux select (grant).
data_sel  output  5  one-hot data-phase mux select.
hmaster  output  3  binary index of addr_sel.
hmaster_data  output  3  binary index of data_sel.

Behaviour:
- Reset (hreset=1 at edge): state=PARK, addr_sel=data_sel=1<<DEF_MASTER, hmaster=hmaster_data=DEF_MASTER, beat_cnt=0, hold_cnt=0. Applies mid-burst or mid-lock; no burst completion is honoured.
- Freeze: when hready=0, every register holds its value.
- States:
  - PARK: no requester owns the bus; the park master is selected.
  - GRANTED: the owner holds the bus.
- Beat counter, on a hready=1 edge:
  - Owner NONSEQ with hburst WRAP4/INCR4: load 3. WRAP8/INCR8: load 7. WRAP16/INCR16: load 15. SINGLE/INCR: load 0.
  - Owner SEQ with beat_cnt>0: decrement.
  - IDLE: clear.
  - BUSY: hold.
- Hold counter:
  - Increments on each hready=1 edge with htrans NONSEQ or SEQ; saturates at all-ones.
  - Clears on any change of addr_sel.
- switch_ok = (beat_cnt==0 after this edge's update, i.e. no fixed burst beats remaining) AND hmastlock==0.
- Arbitration on a hready=1 edge with switch_ok=1:
  - Owner's hbusreq=1 and (MAX_HOLD==0 or hold_cnt<MAX_HOLD or no other request): keep owner.
  - Otherwise: grant the first requester found searching owner+1, owner+2, ... mod 5, wrapping. The owner itself is searched last.
  - No requests: PARK on DEF_MASTER. A DEF_MASTER request while in PARK gives GRANTED with no select change.
- switch_ok=0: keep owner regardless of hbusreq. An owner dropping its request mid-burst keeps the bus until beat_cnt reaches 0.
- Latency:
  - addr_sel is registered. A grant decision at edge N is visible after edge N.
  - data_sel <= addr_sel on every hready=1 edge, so the data phase lags the address phase by exactly one accepted beat.
- Invariants: addr_sel and data_sel are always exactly one-hot (never 0, never multi-hot). hmaster and hmaster_data always encode them.
- Requests from index ≥5 do not exist; hbusreq is exactly 5 bits.

Decomposition:
- Shared package/include ahb_defs holds:
  - HTRANS and HBURST encodings.
  - burst-length decode constants (3/7/15).
  - NUM_MASTERS=5.
- One sub-module, rr_pick5: combinational rotate-priority pick. Inputs: 5-bit request and 3-bit last owner. Outputs: one-hot grant and valid.
- Counters, FSM and select registers stay in ahb_arbiter5.

Test Plan:
- Reset then idle: hreset=1 for 2 cycles, DEF_MASTER=0, hbusreq=0 -> addr_sel=data_sel=5'b00001, hmaster=0, state PARK.
- Simple grant: hbusreq=5'b00100 at edge N, hready=1 -> addr_sel=5'b00100 after N, hmaster=2; data_sel=5'b00100 after N+1.
- Round-robin: owner 2, hbusreq=5'b11011, owner drops request at a NONSEQ SINGLE -> grant goes to 3, then 4, then 0, then 1 on successive releases.
- Burst protection: owner 1 issues NONSEQ INCR4, hbusreq[1] drops on beat 1, hbusreq[3]=1 -> addr_sel stays 5'b00010 through 3 more SEQ beats; switches to 5'b01000 only after the 4th beat is accepted.
- Wait states and lock: hready=0 for 3 cycles with new requests pending -> all outputs unchanged. With hmastlock=1 and MAX_HOLD=4, owner keeps the bus for 10 beats; it rotates on the first edge with hmastlock=0.
- Hold limit and reset mid-burst: MAX_HOLD=4, master 0 continuous INCR, hbusreq=5'b10001 -> switches to 4 after 4 beats. Assert hreset during the 2nd beat of a WRAP8 -> next cycle addr_sel=5'b00001, beat_cnt=0.
